// File: rtl/sub_serial.sv
// Bit-serial N-bit subtractor: computes a - b LSB-first through one full-subtractor
// cell and a borrow flip-flop, with a start/busy/done handshake.
module sub_serial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state_reg;
  logic [N-1:0]  sa_reg;
  logic [N-1:0]  sb_reg;
  logic [N-1:0]  sd_reg;
  logic          bin_reg;
  logic [CW-1:0] cnt_reg;

  logic          d_bit;
  logic          bout;
  logic [N-1:0]  sd_next;

  // Full-subtractor cell fed by the operand LSBs and the registered borrow
  assign d_bit   = sa_reg[0] ^ sb_reg[0] ^ bin_reg;
  assign bout    = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & bin_reg);
  assign sd_next = {d_bit, sd_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sd_reg    <= '0;
      bin_reg   <= 1'b0;
      cnt_reg   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            sd_reg    <= '0;
            bin_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sd_reg  <= sd_next;
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          bin_reg <= bout;
          cnt_reg <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(N - 1)) begin
            diff      <= sd_next;
            borrow    <= bout;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          // A start in the done cycle chains straight into the next operation
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            sd_reg    <= '0;
            bin_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= S_SHIFT;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: 8-bit scenarios plus an exhaustive 4-bit sweep.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0;
  logic [3:0] b4 = '0;
  logic       busy4, done4, borrow4;
  logic [3:0] diff4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_serial #(.N(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  sub_serial #(.N(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4)
  );

  // Issue one 8-bit operation; lat = edges after the accepting edge until done (-1 on timeout)
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     output logic [7:0] dv, output logic bo, output int lat);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
    end
    dv = diff8; bo = borrow8;
    $display("op8 a=%02h b=%02h -> diff=%02h borrow=%0d lat=%0d", av, bv, dv, bo, lat);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv,
                     output logic [3:0] dv, output logic bo, output int lat);
    a4 = av; b4 = bv; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done4) begin lat = n; break; end
    end
    dv = diff4; bo = borrow4;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b diff=%02h borrow=%b want all 0", busy8, done8, diff8, borrow8);
    end
    checks++;
    if ({busy4, done4, diff4, borrow4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4 got busy=%b done=%b diff=%h borrow=%b want all 0", busy4, done4, diff4, borrow4);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset done");
  endtask

  task automatic test_basic();
    int busy_bad = 0;
    a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    if (busy8 !== 1'b1 || done8 !== 1'b0) busy_bad++;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy8 !== 1'b1 || done8 !== 1'b0) busy_bad++;
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL basic_busy got %0d bad busy/done cycles want 0", busy_bad);
    end
    @(posedge clk); #1;
    checks++;
    if ({done8, busy8, diff8, borrow8} !== {1'b1, 1'b0, 8'h02, 1'b0}) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b diff=%02h borrow=%b want 1 0 02 0", done8, busy8, diff8, borrow8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || diff8 !== 8'h02) begin
      errors++;
      $display("FAIL basic_pulse got done=%b diff=%02h want done=0 diff=02", done8, diff8);
    end
    $display("basic a=05 b=03 -> diff=%02h borrow=%0d", diff8, borrow8);
  endtask

  task automatic test_vectors();
    logic [7:0] va [4] = '{8'h03, 8'h00, 8'hFF, 8'h00};
    logic [7:0] vb [4] = '{8'h05, 8'hFF, 8'h01, 8'h00};
    logic [7:0] vd [4] = '{8'hFE, 8'h01, 8'hFE, 8'h00};
    logic       vr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] d;
    logic       br;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      op8(va[i], vb[i], d, br, lat);
      checks++;
      if (d !== vd[i] || br !== vr[i] || lat != 8) begin
        errors++;
        $display("FAIL vec%0d got diff=%02h borrow=%b lat=%0d want diff=%02h borrow=%b lat=8",
                 i, d, br, lat, vd[i], vr[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 3) begin a8 = 8'd1; b8 = 8'd2; start8 = 1'b1; end
      if (n == 5) start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) begin
        dones++;
        checks++;
        if (diff8 !== 8'h05 || borrow8 !== 1'b0) begin
          errors++;
          $display("FAIL busy_start_result got diff=%02h borrow=%b want 05 0", diff8, borrow8);
        end
      end
    end
    checks++;
    if (dones != 1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_count got dones=%0d busy=%b want 1 0", dones, busy8);
    end
    $display("start-while-busy a=09 b=04 -> dones=%0d diff=%02h", dones, diff8);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       br;
    int         lat;
    int         gap = -1;
    int         held_bad = 0;
    op8(8'h09, 8'h04, d, br, lat);
    // Now in the done cycle: chain the second operation
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      start8 = 1'b0;
      if (done8) begin gap = n; break; end
      if (diff8 !== 8'h05 || borrow8 !== 1'b0) held_bad++;
    end
    checks++;
    if (gap != 9) begin
      errors++;
      $display("FAIL b2b_gap got %0d cycles want 9", gap);
    end
    checks++;
    if (held_bad != 0) begin
      errors++;
      $display("FAIL b2b_held got %0d cycles with changed result want 0", held_bad);
    end
    checks++;
    if (diff8 !== 8'hF0 || borrow8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_result got diff=%02h borrow=%b want F0 1", diff8, borrow8);
    end
    $display("back-to-back a=10 b=20 -> diff=%02h borrow=%0d gap=%0d", diff8, borrow8, gap);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       br;
    int         lat;
    int         dones = 0;
    a8 = 8'h30; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
      errors++;
      $display("FAIL midreset got busy=%b done=%b diff=%02h borrow=%b want all 0", busy8, done8, diff8, borrow8);
    end
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_nodone got %0d done pulses want 0", dones);
    end
    op8(8'h07, 8'h07, d, br, lat);
    checks++;
    if (d !== 8'h00 || br !== 1'b0 || lat != 8) begin
      errors++;
      $display("FAIL midreset_fresh got diff=%02h borrow=%b lat=%0d want 00 0 8", d, br, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4();
    logic [3:0] d;
    logic       br;
    int         lat;
    logic [4:0] ref5;
    int         row_err;
    for (int i = 0; i < 16; i++) begin
      row_err = 0;
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j), d, br, lat);
        ref5 = {1'b0, 4'(i)} - {1'b0, 4'(j)};
        checks++;
        if (d !== ref5[3:0] || br !== (i < j) || lat != 4) begin
          errors++;
          row_err++;
          $display("FAIL ex4 a=%h b=%h got diff=%h borrow=%b lat=%0d want diff=%h borrow=%b lat=4",
                   i, j, d, br, lat, ref5[3:0], (i < j));
        end
      end
      $display("ex4 row a=%h: 16 pairs, %0d bad", i, row_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
